// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: clears the accumulator on start, accumulates
// len_i operand-pair products over a valid/ready stream, then holds the sum for the consumer.
module mac_seq_ctrl #(
    parameter int unsigned IWIDTH = 4,
    parameter int unsigned SWIDTH = 10,
    parameter int unsigned LWIDTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IWIDTH-1:0] a_i,
    input  logic [IWIDTH-1:0] b_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [SWIDTH-1:0] res_o,
    output logic              ovf_o
);

    localparam int unsigned PWIDTH = 2 * IWIDTH;
    localparam int unsigned SUMW   = SWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SWIDTH-1:0]   r_acc;
    logic [SWIDTH-1:0]   w_acc_nxt;
    logic                r_ovf;
    logic                w_ovf_nxt;
    logic [LWIDTH-1:0]   r_cnt;
    logic [LWIDTH-1:0]   w_cnt_nxt;
    logic [LWIDTH-1:0]   r_len;
    logic [LWIDTH-1:0]   w_len_nxt;
    logic                r_busy;
    logic                r_in_ready;
    logic                r_res_valid;

    logic [PWIDTH-1:0]   w_prod;
    logic [SUMW-1:0]     w_sum;
    logic [LWIDTH-1:0]   w_cnt_inc;
    logic                w_accept;

    // Product is fitted to the accumulator width; the extra sum bit is the wrap carry.
    assign w_prod    = PWIDTH'(a_i) * PWIDTH'(b_i);
    assign w_sum     = SUMW'(r_acc) + SUMW'(SWIDTH'(w_prod));
    assign w_cnt_inc = r_cnt + LWIDTH'(1);
    assign w_accept  = in_valid_i & r_in_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_in_ready  <= (w_state_nxt == S_RUN);
            r_res_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_len_nxt   = len_i;
                    w_state_nxt = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[SWIDTH-1:0];
                    w_ovf_nxt = r_ovf | w_sum[SWIDTH];
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (r_res_valid && res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy_o      = r_busy;
    assign in_ready_o  = r_in_ready;
    assign res_valid_o = r_res_valid;
    assign res_o       = r_acc;
    assign ovf_o       = r_ovf;

endmodule
